// File: rtl/ps2_ace_keyboard_pkg.sv
// Shared constants and PS/2 set-2 scancode to Jupiter Ace 8x5 matrix mapping.
`timescale 1ns/1ps
package ace_kbd_pkg;

  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 5;

  localparam logic [2:0] ROW_0 = 3'd0;  // SHIFT SYMSHIFT Z X C
  localparam logic [2:0] ROW_1 = 3'd1;  // A S D F G
  localparam logic [2:0] ROW_2 = 3'd2;  // Q W E R T
  localparam logic [2:0] ROW_3 = 3'd3;  // 1 2 3 4 5
  localparam logic [2:0] ROW_4 = 3'd4;  // 0 9 8 7 6
  localparam logic [2:0] ROW_5 = 3'd5;  // P O I U Y
  localparam logic [2:0] ROW_6 = 3'd6;  // ENTER L K J H
  localparam logic [2:0] ROW_7 = 3'd7;  // SPACE M N B V

  localparam logic [2:0] COL_0 = 3'd0;
  localparam logic [2:0] COL_1 = 3'd1;
  localparam logic [2:0] COL_2 = 3'd2;
  localparam logic [2:0] COL_3 = 3'd3;
  localparam logic [2:0] COL_4 = 3'd4;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_ACK   = 8'hFA;
  localparam logic [7:0] SC_ECHO  = 8'hEE;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } key_loc_t;

  function automatic key_loc_t mk_loc(input logic [2:0] row, input logic [2:0] col);
    key_loc_t k;
    k.valid = 1'b1;
    k.row   = row;
    k.col   = col;
    return k;
  endfunction

  // Codes absent from the table (including ACK/ECHO) come back with valid=0.
  function automatic key_loc_t std_lookup(input logic [7:0] code);
    key_loc_t k;
    k = '0;
    case (code)
      8'h12, 8'h59: k = mk_loc(ROW_0, COL_0);
      8'h14: k = mk_loc(ROW_0, COL_1);
      8'h1A: k = mk_loc(ROW_0, COL_2);
      8'h22: k = mk_loc(ROW_0, COL_3);
      8'h21: k = mk_loc(ROW_0, COL_4);
      8'h1C: k = mk_loc(ROW_1, COL_0);
      8'h1B: k = mk_loc(ROW_1, COL_1);
      8'h23: k = mk_loc(ROW_1, COL_2);
      8'h2B: k = mk_loc(ROW_1, COL_3);
      8'h34: k = mk_loc(ROW_1, COL_4);
      8'h15: k = mk_loc(ROW_2, COL_0);
      8'h1D: k = mk_loc(ROW_2, COL_1);
      8'h24: k = mk_loc(ROW_2, COL_2);
      8'h2D: k = mk_loc(ROW_2, COL_3);
      8'h2C: k = mk_loc(ROW_2, COL_4);
      8'h16: k = mk_loc(ROW_3, COL_0);
      8'h1E: k = mk_loc(ROW_3, COL_1);
      8'h26: k = mk_loc(ROW_3, COL_2);
      8'h25: k = mk_loc(ROW_3, COL_3);
      8'h2E: k = mk_loc(ROW_3, COL_4);
      8'h45: k = mk_loc(ROW_4, COL_0);
      8'h46: k = mk_loc(ROW_4, COL_1);
      8'h3E: k = mk_loc(ROW_4, COL_2);
      8'h3D: k = mk_loc(ROW_4, COL_3);
      8'h36: k = mk_loc(ROW_4, COL_4);
      8'h4D: k = mk_loc(ROW_5, COL_0);
      8'h44: k = mk_loc(ROW_5, COL_1);
      8'h43: k = mk_loc(ROW_5, COL_2);
      8'h3C: k = mk_loc(ROW_5, COL_3);
      8'h35: k = mk_loc(ROW_5, COL_4);
      8'h5A: k = mk_loc(ROW_6, COL_0);
      8'h4B: k = mk_loc(ROW_6, COL_1);
      8'h42: k = mk_loc(ROW_6, COL_2);
      8'h3B: k = mk_loc(ROW_6, COL_3);
      8'h33: k = mk_loc(ROW_6, COL_4);
      8'h29: k = mk_loc(ROW_7, COL_0);
      8'h3A: k = mk_loc(ROW_7, COL_1);
      8'h31: k = mk_loc(ROW_7, COL_2);
      8'h32: k = mk_loc(ROW_7, COL_3);
      8'h2A: k = mk_loc(ROW_7, COL_4);
      default: k = '0;
    endcase
    return k;
  endfunction

  // Only right Ctrl and keypad Enter are meaningful after an E0 prefix.
  function automatic key_loc_t ext_lookup(input logic [7:0] code);
    key_loc_t k;
    k = '0;
    case (code)
      8'h14:   k = mk_loc(ROW_0, COL_1);
      8'h5A:   k = mk_loc(ROW_6, COL_0);
      default: k = '0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/ps2_ace_keyboard_if.sv
// PS/2 line inputs and the ULA-facing row/column bus of the Ace keyboard.
`timescale 1ns/1ps
interface ps2_ace_keyboard_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] filas;
  logic [4:0] columnas;
  logic       key_strobe;
  logic       frame_err;

  modport slave (
    input  ps2_clk, ps2_data, filas,
    output columnas, key_strobe, frame_err
  );

  modport master (
    output ps2_clk, ps2_data, filas,
    input  columnas, key_strobe, frame_err
  );
endinterface

// File: rtl/ps2_ace_keyboard_ps2_rx.sv
// PS/2 receiver: line synchronisers, clock glitch filter, frame FSM and timeout.
`timescale 1ns/1ps
module ps2_rx
  import ace_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 6500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic [FW-1:0] filt_cnt;
  logic          clk_filt;
  logic          fall;

  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] to_cnt;

  // Sync stage: both lines idle high, so synchronisers reset to 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Filter stage: a new level must persist FILTER_LEN samples in a row
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
      clk_filt <= clk_sync[1];
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign fall = clk_filt && !clk_sync[1] && (filt_cnt == FW'(FILTER_LEN - 1));

  // Frame stage: odd parity over data+parity, stop bit must be 1
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RX_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        case (state)
          RX_IDLE: begin
            if (!data_sync[1]) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            shreg   <= {data_sync[1], shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_PARITY;
          end
          RX_PARITY: begin
            par_bit <= data_sync[1];
            state   <= RX_STOP;
          end
          RX_STOP: begin
            if (data_sync[1] && (^{par_bit, shreg})) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              rx_err <= 1'b1;
            end
            state <= RX_IDLE;
          end
          default: state <= RX_IDLE;
        endcase
      end else if (state != RX_IDLE) begin
        if (to_cnt == TW'(TIMEOUT - 1)) begin
          state  <= RX_IDLE;
          to_cnt <= '0;
          rx_err <= 1'b1;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_ace_keyboard.sv
// Jupiter Ace keyboard matrix emulated from a PS/2 keyboard; rows in, columns out.
`timescale 1ns/1ps
module ps2_ace_keyboard
  import ace_kbd_pkg::*;
#(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 6500
) (
  input  logic              clk,
  input  logic              reset,
  ps2_ace_keyboard_if.slave bus
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;

  logic [NUM_ROWS-1:0][NUM_COLS-1:0] matrix;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0] matrix_nx;
  logic     brk, ext, brk_nx, ext_nx;
  key_loc_t loc;
  logic     key_strobe_r, frame_err_r;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (bus.ps2_clk),
    .ps2_data (bus.ps2_data),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err)
  );

  // Decode stage: prefixes only latch flags; any other byte consumes them
  always_comb begin
    matrix_nx = matrix;
    brk_nx    = brk;
    ext_nx    = ext;
    loc       = ext ? ext_lookup(rx_byte) : std_lookup(rx_byte);
    if (rx_err) begin
      matrix_nx = '0;
      brk_nx    = 1'b0;
      ext_nx    = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_BREAK) begin
        brk_nx = 1'b1;
      end else if (rx_byte == SC_EXT) begin
        ext_nx = 1'b1;
      end else begin
        brk_nx = 1'b0;
        ext_nx = 1'b0;
        if (rx_byte == SC_BAT && !brk && !ext) begin
          matrix_nx = '0;
        end else if (loc.valid) begin
          matrix_nx[loc.row][loc.col] = ~brk;
        end
      end
    end
  end

  // Matrix stage
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      matrix       <= '0;
      brk          <= 1'b0;
      ext          <= 1'b0;
      key_strobe_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      matrix       <= matrix_nx;
      brk          <= brk_nx;
      ext          <= ext_nx;
      key_strobe_r <= (matrix_nx != matrix);
      frame_err_r  <= rx_err;
    end
  end

  // A column is pulled low by any selected row holding a pressed key there
  always_comb begin
    for (int c = 0; c < NUM_COLS; c++) begin
      logic hit;
      hit = 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        hit = hit | (~bus.filas[r] & matrix[r][c]);
      end
      bus.columnas[c] = ~hit;
    end
  end

  assign bus.key_strobe = key_strobe_r;
  assign bus.frame_err  = frame_err_r;

endmodule

// File: tb/tb_ps2_ace_keyboard.sv
// Directed bench: PS/2 frames driven bit by bit, matrix observed through row/column bus.
`timescale 1ns/1ps
module tb_ps2_ace_keyboard;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 6500;
  localparam int HALF       = 20;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;
  int   n_strobe;
  int   n_err;
  logic [4:0] col_at_strobe;

  ps2_ace_keyboard_if kif ();

  ps2_ace_keyboard #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (kif.key_strobe) begin
      n_strobe++;
      col_at_strobe = kif.columnas;
    end
    if (kif.frame_err) n_err++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    kif.ps2_data = b;
    wait_cyc(HALF);
    kif.ps2_clk = 1'b0;
    wait_cyc(HALF);
    kif.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) send_bit(bits[i]);
    kif.ps2_data = 1'b1;
    wait_cyc(40);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(b[i]);
    kif.ps2_data = 1'b1;
  endtask

  task automatic chk_cols(input string name, input logic [4:0] want);
    n_checks++;
    if (kif.columnas !== want) begin
      n_fail++;
      $display("FAIL %s: columnas got %b want %b", name, kif.columnas, want);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    kif.ps2_clk  = 1'b1;
    kif.ps2_data = 1'b1;
    kif.filas    = 8'h00;
    wait_cyc(5);
    if (kif.columnas !== 5'b11111) begin
      n_fail++;
      $display("FAIL reset_cols: got %b want %b", kif.columnas, 5'b11111);
    end
    n_checks++;
    if (kif.key_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_strobe: got %b want 0", kif.key_strobe);
    end
    n_checks++;
    if (kif.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_err: got %b want 0", kif.frame_err);
    end
    n_checks++;
    reset = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_press_release;
    int s0;
    kif.filas = 8'hFE;
    s0 = n_strobe;
    send_frame(8'h1A, 1'b0);
    chk_int("press_strobe", n_strobe - s0, 1);
    chk_int("press_cols_at_strobe", int'(col_at_strobe), int'(5'b11011));
    chk_cols("press_cols", 5'b11011);
    s0 = n_strobe;
    send_frame(8'hF0, 1'b0);
    chk_int("break_prefix_strobe", n_strobe - s0, 0);
    chk_cols("break_prefix_cols", 5'b11011);
    send_frame(8'h1A, 1'b0);
    chk_int("release_strobe", n_strobe - s0, 1);
    chk_cols("release_cols", 5'b11111);
  endtask

  task automatic test_bad_parity;
    int s0, e0;
    kif.filas = 8'hFE;
    send_frame(8'h1A, 1'b0);
    chk_cols("pre_parity_cols", 5'b11011);
    s0 = n_strobe;
    e0 = n_err;
    send_frame(8'h1A, 1'b1);
    chk_int("parity_err", n_err - e0, 1);
    chk_int("parity_clear_strobe", n_strobe - s0, 1);
    chk_cols("parity_cols", 5'b11111);
  endtask

  task automatic test_timeout;
    int e0;
    e0 = n_err;
    send_partial(8'h29, 4);
    wait_cyc(TIMEOUT + 10);
    chk_int("timeout_err", n_err - e0, 1);
    kif.filas = 8'h7F;
    send_frame(8'h29, 1'b0);
    chk_int("after_timeout_err", n_err - e0, 1);
    chk_cols("after_timeout_space", 5'b11110);
  endtask

  task automatic test_or_rows;
    int s0;
    send_frame(8'hAA, 1'b0);
    kif.filas = 8'h7F;
    wait_cyc(2);
    chk_cols("bat_clear", 5'b11111);
    s0 = n_strobe;
    send_frame(8'h12, 1'b0);
    send_frame(8'h5A, 1'b0);
    chk_int("or_press_strobes", n_strobe - s0, 2);
    kif.filas = 8'h3E;
    wait_cyc(1);
    chk_cols("or_rows_0_6", 5'b11110);
    kif.filas = 8'hBF;
    wait_cyc(1);
    chk_cols("row6_only", 5'b11110);
    s0 = n_strobe;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h12, 1'b0);
    send_frame(8'h59, 1'b0);
    chk_int("ext12_and_rshift_strobe", n_strobe - s0, 0);
    s0 = n_strobe;
    send_frame(8'hF0, 1'b0);
    send_frame(8'h12, 1'b0);
    chk_int("shared_release_strobe", n_strobe - s0, 1);
    kif.filas = 8'hFE;
    wait_cyc(1);
    chk_cols("shared_release_row0", 5'b11111);
    kif.filas = 8'h3E;
    wait_cyc(1);
    chk_cols("enter_still_held", 5'b11110);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h5A, 1'b0);
    kif.filas = 8'hBF;
    wait_cyc(1);
    chk_cols("ext_enter_release", 5'b11111);
    send_frame(8'hE0, 1'b0);
    send_frame(8'h14, 1'b0);
    kif.filas = 8'hFE;
    wait_cyc(1);
    chk_cols("ext_symshift", 5'b11101);
    s0 = n_strobe;
    send_frame(8'hFA, 1'b0);
    chk_int("ack_ignored", n_strobe - s0, 0);
  endtask

  task automatic test_glitch;
    int s0, e0;
    send_frame(8'hAA, 1'b0);
    kif.filas = 8'hFE;
    s0 = n_strobe;
    e0 = n_err;
    kif.ps2_data = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #3 kif.ps2_clk = 1'b0;
      #1 kif.ps2_clk = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      wait_cyc(10);
      kif.ps2_clk = 1'b0;
      wait_cyc(FILTER_LEN - 3);
      kif.ps2_clk = 1'b1;
    end
    kif.ps2_data = 1'b1;
    wait_cyc(20);
    chk_int("glitch_no_strobe", n_strobe - s0, 0);
    send_frame(8'h22, 1'b0);
    chk_int("glitch_no_err", n_err - e0, 0);
    chk_cols("glitch_then_x", 5'b10111);
  endtask

  task automatic test_reset_midframe;
    int e0;
    kif.filas = 8'hFE;
    send_frame(8'h1A, 1'b0);
    chk_cols("pre_reset_cols", 5'b10011);
    send_partial(8'h29, 3);
    #3 reset = 1'b0;
    #1;
    chk_cols("reset_mid_cols", 5'b11111);
    n_checks++;
    if (kif.key_strobe !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_strobe: got %b want 0", kif.key_strobe);
    end
    wait_cyc(5);
    reset = 1'b1;
    wait_cyc(20);
    e0 = n_err;
    send_frame(8'h1A, 1'b0);
    chk_int("post_reset_err", n_err - e0, 0);
    chk_cols("post_reset_z", 5'b11011);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    n_strobe = 0;
    n_err    = 0;
    col_at_strobe = '1;
    test_reset();
    test_press_release();
    test_bad_parity();
    test_timeout();
    test_or_rows();
    test_glitch();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_ace_keyboard.md
PS2_ACE_KEYBOARD -- requirements
Module: ps2_ace_keyboard

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 8: clk cycles ps2_clk must hold a new level before it is accepted.
REQ-002 SHALL have parameter TIMEOUT, default 6500: clk cycles without a filtered ps2_clk falling edge before a partial frame is abandoned.
REQ-003 clk  input  1  sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  PS/2 keyboard clock, asynchronous.
REQ-006 ps2_data  input  1  PS/2 keyboard data, asynchronous.
REQ-007 filas  input  8  keyboard row select (CPU A15..A8), active-low; bit r selects row r.
REQ-008 columnas  output  5  column sense to the ULA logic, active-low.
REQ-009 key_strobe  output  1  one-cycle pulse whenever the key matrix changes.
REQ-010 frame_err  output  1  one-cycle pulse on a rejected or timed-out frame.

Function
REQ-011 ps2_clk and ps2_data SHALL each pass through a 2-flop synchroniser; filtered ps2_clk changes only after FILTER_LEN consecutive equal synchronised samples.
REQ-012 Receiver FSM states: IDLE, DATA, PARITY, STOP; each transition and each sample occurs on a filtered ps2_clk falling edge.
REQ-013 IDLE: sample 0 -> DATA with bit count 0; sample 1 -> stay IDLE, no error.
REQ-014 DATA: shift in LSB first; after 8th bit -> PARITY.
REQ-015 PARITY: capture bit -> STOP. STOP: if stop=1 and odd parity over 9 bits, deliver byte; otherwise frame_err; always -> IDLE.
REQ-016 In any non-IDLE state, TIMEOUT cycles without a falling edge SHALL force IDLE and pulse frame_err.
REQ-017 Delivered byte processed in the cycle after STOP; matrix update visible on columnas one cycle later (two clk after the STOP edge).
REQ-018 Decoder: 0xF0 sets break flag; 0xE0 sets ext flag; any other byte is applied and then both flags clear.
REQ-019 Non-extended mapped code: matrix[row][col] <= ~break. Mapping per package table (Jupiter Ace 8x5 layout; e.g. 0x12/0x59 -> row0 col0 SHIFT, 0x14 -> row0 col1 SYMSHIFT, 0x1A -> row0 col2 Z, 0x5A -> row6 col0 ENTER, 0x29 -> row7 col0 SPACE).
REQ-020 Extended codes: E0 14 -> SYMSHIFT; E0 5A -> ENTER; all other E0 codes, including E0 12, ignored.
REQ-021 Unmapped codes, and 0xFA / 0xEE, SHALL be ignored and clear both flags.
REQ-022 0xAA with no prefix, or any frame_err, SHALL clear the whole matrix and both flags.
REQ-023 Two scancodes sharing a cell (LShift/RShift) share one bit; last event wins.
REQ-024 columnas[c] = 0 iff some r has filas[r]=0 and matrix[r][c]=1; combinational from filas and registered matrix; several low filas bits OR their rows.
REQ-025 key_strobe pulses only when at least one matrix bit actually changes.

Reset
REQ-026 On reset low: FSM IDLE, counters 0, flags 0, matrix all 0, synchroniser and filter state 1, key_strobe 0, frame_err 0, columnas 5'b11111.
REQ-027 Reset mid-frame SHALL discard the partial frame; the first valid frame after release is decoded normally.

Structure
REQ-028 Shared package ace_kbd_pkg SHALL hold row/column index constants and the scancode-to-(row,col,valid) table, standard and extended.
REQ-029 A single sub-module ps2_rx SHALL hold the synchroniser, filter, FSM and timeout and output byte + valid + error pulses; decoder and matrix stay at top level.

Verification
REQ-030 Frame 0x1A with good parity, filas=8'hFE -> columnas=5'b11011 two clk after STOP; key_strobe one pulse.
REQ-031 F0 1A after that -> columnas=5'b11111; key_strobe one pulse; F0 byte alone produces no strobe.
REQ-032 Frame 0x1A with bad parity -> frame_err pulse, matrix cleared, columnas=5'b11111.
REQ-033 Stall after 4 data bits for TIMEOUT+10 cycles -> frame_err pulse, FSM IDLE; next frame 0x29 sets SPACE (filas=8'h7F -> columnas=5'b11110).
REQ-034 Press 0x12 and 0x5A, filas=8'h3E -> columnas=5'b11110 (rows 0 and 6 ORed); E0 12 changes nothing.
REQ-035 1 ns glitches on ps2_clk shorter than FILTER_LEN cycles -> no bit sampled; reset asserted mid-frame -> columnas=5'b11111 immediately.
